// File: rtl/modulo_temporizador_bcd_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encoding, digit limits
// and the load-value clamp used by both digits.
package modulo_temporizador_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

endpackage

// File: rtl/modulo_temporizador_bcd_digito.sv
// One BCD down-counting digit: loads a value, decrements on the falling edge
// when enabled, wraps 0 to max_val and reports the borrow to the next digit.
module modulo_digito_bcd_dec (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       enable,
    input  logic [3:0] max_val,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic       borrow_out
);

    logic step;

    assign step       = enable && borrow_in;
    // Borrow only on the edge where this digit wraps, so the next digit moves once.
    assign borrow_out = step && (value == 4'd0);

    always_ff @(negedge clk or posedge clr) begin
        if (clr)
            value <= 4'd0;
        else if (load)
            value <= load_val;
        else if (step)
            value <= (value == 4'd0) ? max_val : value - 4'd1;
    end

endmodule

// File: rtl/modulo_temporizador_bcd.sv
// Two-digit BCD countdown timer with load/start/pause control and a one-cycle
// done pulse; all state moves on the falling edge of clk.
module modulo_temporizador_bcd
    import modulo_temporizador_bcd_pkg::*;
#(
    parameter int TENS_MAX = 9
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       running,
    output logic       done
);

    localparam logic [3:0] TENS_MAX_D = 4'(TENS_MAX);

    state_t     state;
    logic       running_q;
    logic       done_q;
    logic       digit_load;
    logic       dec_en;
    logic       units_borrow;
    logic       tens_borrow_unused;
    logic       at_zero;
    logic       at_one;
    logic [3:0] units_ld;
    logic [3:0] tens_ld;

    assign units_ld   = clamp_digit(load_val[3:0], BCD_MAX);
    assign tens_ld    = clamp_digit(load_val[7:4], TENS_MAX_D);
    assign at_zero    = (tens == 4'd0) && (units == 4'd0);
    assign at_one     = (tens == 4'd0) && (units == 4'd1);

    // Load is dead while counting; pause outranks tick on the same edge.
    assign digit_load = load && (state != RUN);
    assign dec_en     = (state == RUN) && tick && !pause && !at_zero;

    modulo_digito_bcd_dec u_units (
        .clk        (clk),
        .clr        (clr),
        .load       (digit_load),
        .load_val   (units_ld),
        .enable     (dec_en),
        .max_val    (BCD_MAX),
        .borrow_in  (1'b1),
        .value      (units),
        .borrow_out (units_borrow)
    );

    modulo_digito_bcd_dec u_tens (
        .clk        (clk),
        .clr        (clr),
        .load       (digit_load),
        .load_val   (tens_ld),
        .enable     (units_borrow),
        .max_val    (TENS_MAX_D),
        .borrow_in  (1'b1),
        .value      (tens),
        .borrow_out (tens_borrow_unused)
    );

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, PAUSE: begin
                    if (load) begin
                        state <= IDLE;
                    end else if (pause) begin
                        state <= state;
                    end else if (start) begin
                        if (at_zero) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state     <= PAUSE;
                        running_q <= 1'b0;
                    end else if (tick && at_one) begin
                        // The digits reach 00 on this same edge.
                        state     <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    if (load)
                        state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign running = running_q;
    assign done    = done_q;

endmodule

// File: doc/modulo_temporizador_bcd.md
MODULO_TEMPORIZADOR_BCD -- requirements
Module: modulo_temporizador_bcd

Interface
REQ-001 SHALL have parameter TENS_MAX, default 9: largest legal tens digit (5 for a 59-second timer).
REQ-002 SHALL have port clk, input, 1: system clock; all state updates occur on the falling edge.
REQ-003 SHALL have port clr, input, 1: reset clr, asynchronous, active-high.
REQ-004 SHALL have port load, input, 1: load load_val into the count.
REQ-005 SHALL have port load_val, input, 8: [7:4] tens BCD, [3:0] units BCD.
REQ-006 SHALL have port start, input, 1: begin or resume countdown.
REQ-007 SHALL have port pause, input, 1: suspend countdown.
REQ-008 SHALL have port tick, input, 1: count strobe, one decrement per sampled-high edge.
REQ-009 SHALL have port units, output, 4: current units digit.
REQ-010 SHALL have port tens, output, 4: current tens digit.
REQ-011 SHALL have port running, output, 1: high only in RUN.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on reaching 00.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE and DONE.
REQ-014 SHALL apply input priority per edge: clr > load > pause > start > tick.
REQ-015 SHALL act on load only in IDLE, PAUSE or DONE: count takes load_val, FSM goes to IDLE, done stays 0; load in RUN SHALL be ignored.
REQ-016 SHALL clamp loaded digits: units > 9 becomes 9; tens > TENS_MAX becomes TENS_MAX.
REQ-017 SHALL, on start in IDLE or PAUSE with count != 00, enter RUN on that edge.
REQ-018 SHALL, on start in IDLE or PAUSE with count == 00, enter DONE and assert done for exactly one cycle.
REQ-019 SHALL, on pause in RUN, enter PAUSE with the count held; pause in other states SHALL have no effect.
REQ-020 SHALL, on tick in RUN, decrement the count by one: units 0 wraps to 9 and borrows one from tens.
REQ-021 SHALL, when a tick takes the count from 01 to 00, on the same edge enter DONE, drop running and assert done for exactly one cycle.
REQ-022 SHALL ignore tick outside RUN; the count SHALL never go below 00 and never wrap to 99.
REQ-023 SHALL keep DONE (count 00, running 0) until load or clr; start in DONE SHALL be ignored.
REQ-024 SHALL drive all outputs from registers, with no combinational path from any input to any output.

Reset
REQ-025 SHALL, while clr is high, immediately force state IDLE, units 0, tens 0, running 0 and done 0, regardless of clk.
REQ-026 SHALL, when clr is asserted mid-RUN, abandon the countdown with no done pulse.
REQ-027 SHALL act on the first falling edge after clr deasserts with normal priority.
REQ-028 SHALL give all registers initial values equal to their reset values.

Structure
REQ-029 SHALL place the state encoding constants (2-bit: IDLE=0, RUN=1, PAUSE=2, DONE=3) and the BCD max-digit constant (9) in the shared project include/package.
REQ-030 SHALL instantiate sub-module modulo_digito_bcd_dec twice, once per digit.
REQ-031 SHALL have modulo_digito_bcd_dec provide: async clr, load, enable, max-value input, borrow-in and borrow-out; it decrements on the falling edge when enabled and wraps 0 to max.
REQ-032 SHALL drive the tens digit's enable from the units digit's borrow-out.

Verification
REQ-033 SHALL cover basic countdown: clr, load 0x12, start, 12 ticks -> count 11,10,09,...,01,00; done high exactly one cycle at 00; running 0.
REQ-034 SHALL cover clamping with TENS_MAX=5: load 0x7C -> tens 5, units 9.
REQ-035 SHALL cover pause/resume: load 0x05, start, 2 ticks (03), pause, 3 ticks -> still 03; start, 3 ticks -> 00 with done pulse.
REQ-036 SHALL cover zero start: load 0x00, start -> DONE on next edge, done one cycle, no running.
REQ-037 SHALL cover priority: in RUN at 07, pause+start+tick on same edge -> PAUSE, count 07; load during RUN -> ignored.
REQ-038 SHALL cover async reset: clr pulse between clock edges at count 04 in RUN -> outputs 0 immediately, no done pulse, IDLE.
